// File: rtl/burst_ram_responder.sv
// Memory-side burst responder for the 4-column direct-mapped cache.
// Serves 4-beat line fills and write-backs from an internal single-port block RAM.
module burst_ram_responder #(
    parameter int ADDRESS_BITWIDTH    = 16,
    parameter int READ_LATENCY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy
);

    localparam int         DEPTH     = 2 ** ADDRESS_BITWIDTH;
    localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BEATS,
        READ_WAIT,
        READ_BEATS
    } state_t;

    state_t state, state_next;

    logic [1:0]                  beat;
    logic [3:0]                  wait_cnt;
    logic [ADDRESS_BITWIDTH-3:0] line;
    logic                        cmd_accept;
    logic                        write_hs;
    logic                        read_hs;

    logic                        ram_en;
    logic                        ram_we;
    logic [1:0]                  ram_col;
    logic [ADDRESS_BITWIDTH-1:0] ram_addr;
    logic [31:0]                 ram_q;
    logic [31:0]                 mem [0:DEPTH-1];

    // Column bits and bits above the RAM range are deliberately dropped (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cmd_address[31:ADDRESS_BITWIDTH+2], cmd_address[3:0]};

    assign ram_addr = {line, ram_col};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The RAM output register doubles as a one-word prefetch buffer during reads,
    // so a stalled beat leaves the next word parked in ram_q until the handshake.
    always_comb begin
        state_next = state;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_col    = beat;
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        wr_ready   = (state == WRITE_BEATS);
        cmd_accept = cmd_valid && cmd_ready;
        write_hs   = wr_valid && wr_ready;
        read_hs    = rd_valid && rd_ready;

        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = cmd_write ? WRITE_BEATS : READ_WAIT;
                end
            end
            WRITE_BEATS: begin
                if (write_hs) begin
                    ram_en  = 1'b1;
                    ram_we  = 1'b1;
                    ram_col = beat;
                    if (beat == 2'd3) begin
                        state_next = IDLE;
                    end
                end
            end
            READ_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    ram_en     = 1'b1;
                    ram_col    = 2'd0;
                    state_next = READ_BEATS;
                end
            end
            READ_BEATS: begin
                if (!rd_valid) begin
                    ram_en  = 1'b1;
                    ram_col = 2'd1;
                end else if (read_hs) begin
                    if (beat == 2'd3) begin
                        state_next = IDLE;
                    end else begin
                        ram_en  = 1'b1;
                        ram_col = beat + 2'd2;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (rst) begin
            ram_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= 2'd0;
            wait_cnt <= 4'd0;
            line     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 32'd0;
        end else begin
            if (cmd_accept) begin
                line <= cmd_address[ADDRESS_BITWIDTH+1:4];
            end
            case (state)
                WRITE_BEATS: begin
                    if (write_hs) begin
                        beat <= beat + 2'd1;
                    end
                end
                READ_WAIT: begin
                    wait_cnt <= (wait_cnt == WAIT_LAST) ? 4'd0 : wait_cnt + 4'd1;
                end
                READ_BEATS: begin
                    if (!rd_valid) begin
                        rd_data  <= ram_q;
                        rd_valid <= 1'b1;
                    end else if (read_hs) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            rd_valid <= 1'b0;
                        end else begin
                            rd_data <= ram_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Plain synchronous single-port RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= wr_data;
            end else begin
                ram_q <= mem[ram_addr];
            end
        end
    end

endmodule
